frame_shift_register: RTL and testbench

Parametrised shift engine for the UART datapath. It loads a frame in parallel, shifts it serially LSB-first or MSB-first on external baud ticks, and counts a per-frame bit length. On completion it signals `done` and presents the captured serial-in bits right-aligned. The TX serializer and RX deserializer both instantiate it: TX uses `shift_out`, RX uses `aligned_out`.

---
 rtl/frame_shift_register.sv | 121 ++++++++++++
 tb/tb_frame_shift_register.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_shift_register.sv
// Parallel-load, serial-shift engine shared by the UART TX and RX paths.
// Shifts LSB- or MSB-first on baud ticks, counts frame bits, and presents received bits right-aligned.
module frame_shift_register #(
    parameter  int WIDTH = 16,
    localparam int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             msb_first,
    input  logic             shift_tick,
    input  logic             shift_in,
    input  logic             abort,
    output logic             shift_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic [WIDTH-1:0] aligned_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] data, data_n;
    logic [WIDTH-1:0] aligned, aligned_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] len, len_n;
    logic             dir, dir_n;
    logic             done_q, done_n;
    logic [LEN_W-1:0] len_clamped;
    logic [WIDTH-1:0] shifted;

    // Right-align the last n received bits; LSB-first frames arrive at the top of the register.
    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] d,
                                               input logic             d_msb,
                                               input logic [LEN_W-1:0] n);
        logic [WIDTH:0] one_w;
        logic [WIDTH:0] m;
        one_w = {{WIDTH{1'b0}}, 1'b1};
        m     = (one_w << n) - one_w;
        if (d_msb) begin
            return d & m[WIDTH-1:0];
        end
        return (d >> (WIDTH - int'(n))) & m[WIDTH-1:0];
    endfunction

    assign len_clamped = (frame_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : frame_len;
    assign shifted     = dir ? {data[WIDTH-2:0], shift_in} : {shift_in, data[WIDTH-1:1]};

    always_comb begin
        state_n   = state;
        data_n    = data;
        aligned_n = aligned;
        cnt_n     = cnt;
        len_n     = len;
        dir_n     = dir;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    data_n = parallel_in;
                    dir_n  = msb_first;
                    cnt_n  = len_clamped;
                    len_n  = len_clamped;
                    if (len_clamped == '0) begin
                        done_n    = 1'b1;
                        aligned_n = '0;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // abort wins over a coincident tick and leaves data untouched
                if (abort) begin
                    state_n = IDLE;
                end else if (shift_tick) begin
                    data_n = shifted;
                    cnt_n  = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        aligned_n = align(shifted, dir, len);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data    <= '0;
            aligned <= '0;
            cnt     <= '0;
            len     <= '0;
            dir     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            data    <= data_n;
            aligned <= aligned_n;
            cnt     <= cnt_n;
            len     <= len_n;
            dir     <= dir_n;
            done_q  <= done_n;
        end
    end

    assign busy         = (state == SHIFT);
    assign start_ready  = ~busy;
    assign shift_out    = dir ? data[WIDTH-1] : data[0];
    assign parallel_out = data;
    assign aligned_out  = aligned;
    assign done         = done_q;

endmodule

// File: tb/tb_frame_shift_register.sv
// Directed bench for frame_shift_register: per-cycle vector table plus hand-written corner sequences.
module tb_frame_shift_register;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] parallel_in;
    logic [LEN_W-1:0] frame_len;
    logic             msb_first;
    logic             shift_tick;
    logic             shift_in;
    logic             abort;
    logic             shift_out;
    logic [WIDTH-1:0] parallel_out;
    logic [WIDTH-1:0] aligned_out;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_shift_register #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .parallel_in  (parallel_in),
        .frame_len    (frame_len),
        .msb_first    (msb_first),
        .shift_tick   (shift_tick),
        .shift_in     (shift_in),
        .abort        (abort),
        .shift_out    (shift_out),
        .parallel_out (parallel_out),
        .aligned_out  (aligned_out),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic        sv;
        logic [15:0] pin;
        logic [4:0]  flen;
        logic        msb;
        logic        tick;
        logic        sin;
        logic        abt;
        logic        e_so;
        logic [15:0] e_po;
        logic [15:0] e_al;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [15:0] pin, input logic [4:0] flen,
                         input logic msb, input logic tick, input logic sin, input logic abt);
        start_valid = sv;
        parallel_in = pin;
        frame_len   = flen;
        msb_first   = msb;
        shift_tick  = tick;
        shift_in    = sin;
        abort       = abt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic sv, input logic [15:0] pin, input logic [4:0] flen,
                       input logic msb, input logic tick, input logic sin, input logic abt,
                       input logic e_so, input logic [15:0] e_po, input logic [15:0] e_al,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.sv = sv; v.pin = pin; v.flen = flen; v.msb = msb; v.tick = tick; v.sin = sin; v.abt = abt;
        v.e_so = e_so; v.e_po = e_po; v.e_al = e_al; v.e_busy = e_busy; v.e_done = e_done;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       tx_bits [8];
        logic [7:0] sin_b;
        logic [7:0] sin_c;
        logic [15:0] po_b [8];
        logic [15:0] po_c [8];
        int          done_cnt;
        int          ticks;

        // Frame A: LSB-first TX of 0x00A5, start_valid held with junk data (ignored while busy)
        add(1, 16'h00A5, 8, 0, 0, 0, 0,  1, 16'h00A5, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  0, 16'h0052, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  1, 16'h0029, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  0, 16'h0014, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  0, 16'h000A, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  1, 16'h0005, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  0, 16'h0002, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  1, 16'h0001, 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, 0, 0,  0, 16'h0000, 16'h0000, 0, 1);
        // Frame B: LSB-first RX of 0x3C, accepted in A's done cycle
        add(1, 16'h0000, 8, 0, 0, 0, 0,  0, 16'h0000, 16'h0000, 1, 0);
        sin_b   = 8'h3C;
        po_b[0] = 16'h0000; po_b[1] = 16'h0000; po_b[2] = 16'h8000; po_b[3] = 16'hC000;
        po_b[4] = 16'hE000; po_b[5] = 16'hF000; po_b[6] = 16'h7800; po_b[7] = 16'h3C00;
        for (int i = 0; i < 7; i++)
            add(1, 16'hFFFF, 3, 1, 1, sin_b[i], 0,  0, po_b[i], 16'h0000, 1, 0);
        add(1, 16'hFFFF, 3, 1, 1, sin_b[7], 0,  0, po_b[7], 16'h003C, 0, 1);
        // Frame C: MSB-first RX of 1,1,0,0,1,0,1,0, accepted in B's done cycle
        add(1, 16'h0000, 8, 1, 0, 0, 0,  0, 16'h0000, 16'h003C, 1, 0);
        sin_c   = 8'b0101_0011;
        po_c[0] = 16'h0001; po_c[1] = 16'h0003; po_c[2] = 16'h0006; po_c[3] = 16'h000C;
        po_c[4] = 16'h0019; po_c[5] = 16'h0032; po_c[6] = 16'h0065; po_c[7] = 16'h00CA;
        for (int i = 0; i < 7; i++)
            add(1, 16'hFFFF, 3, 0, 1, sin_c[i], 0,  0, po_c[i], 16'h003C, 1, 0);
        add(1, 16'hFFFF, 3, 0, 1, sin_c[7], 0,  0, po_c[7], 16'h00CA, 0, 1);
        // Tick in IDLE: nothing moves
        add(0, 16'h0000, 0, 0, 1, 1, 0,  0, 16'h00CA, 16'h00CA, 0, 0);
        // Frame D: MSB-first, length 1
        add(1, 16'h8000, 1, 1, 0, 0, 0,  1, 16'h8000, 16'h00CA, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 1, 0,  0, 16'h0001, 16'h0001, 0, 1);
        // Frame E: zero length, then abort in IDLE
        add(1, 16'h1234, 0, 0, 0, 0, 0,  0, 16'h1234, 16'h0000, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 0, 1,  0, 16'h1234, 16'h0000, 0, 0);

        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        cyc();
        chk1 ("rst_shift_out",   shift_out,    1'b0);
        chk16("rst_parallel",    parallel_out, 16'h0000);
        chk16("rst_aligned",     aligned_out,  16'h0000);
        chk1 ("rst_busy",        busy,         1'b0);
        chk1 ("rst_done",        done,         1'b0);
        chk1 ("rst_start_ready", start_ready,  1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].pin, tbl[i].flen, tbl[i].msb, tbl[i].tick, tbl[i].sin, tbl[i].abt);
            cyc();
            chk1 ($sformatf("vec%0d_shift_out", i), shift_out,    tbl[i].e_so);
            chk16($sformatf("vec%0d_parallel", i),  parallel_out, tbl[i].e_po);
            chk16($sformatf("vec%0d_aligned", i),   aligned_out,  tbl[i].e_al);
            chk1 ($sformatf("vec%0d_busy", i),      busy,         tbl[i].e_busy);
            chk1 ($sformatf("vec%0d_done", i),      done,         tbl[i].e_done);
            chk1 ($sformatf("vec%0d_ready", i),     start_ready,  ~tbl[i].e_busy);
        end

        // LSB-first TX with a tick every 4th cycle
        tx_bits[0] = 1; tx_bits[1] = 0; tx_bits[2] = 1; tx_bits[3] = 0;
        tx_bits[4] = 0; tx_bits[5] = 1; tx_bits[6] = 0; tx_bits[7] = 1;
        done_cnt = 0;
        drive(1, 16'h00A5, 8, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk1($sformatf("spaced_bit%0d", i), shift_out, tx_bits[i]);
            drive(0, 16'h0000, 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                cyc();
                if (done) done_cnt++;
            end
            drive(0, 16'h0000, 0, 0, 1, 0, 0);
            cyc();
            if (done) done_cnt++;
        end
        chk1("spaced_done_after_last", done, 1'b1);
        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (done) done_cnt++;
        end
        chk16("spaced_done_count", 16'(done_cnt), 16'd1);
        chk16("spaced_parallel",   parallel_out,  16'h0000);

        // Length 20 clamps to 16 ticks
        drive(1, 16'h0000, 20, 0, 0, 0, 0);
        cyc();
        ticks = 0;
        for (int k = 0; k < 40; k++) begin
            drive(0, 16'h0000, 0, 0, 1, 1, 0);
            cyc();
            ticks++;
            if (done) break;
        end
        chk16("clamp_ticks",   16'(ticks),  16'd16);
        chk16("clamp_aligned", aligned_out, 16'hFFFF);

        // Abort coincident with the 4th tick: only 3 shifts take effect
        drive(1, 16'h00FF, 8, 0, 0, 0, 0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            drive(0, 16'h0000, 0, 0, 1, 0, 0);
            cyc();
        end
        drive(0, 16'h0000, 0, 0, 1, 0, 1);
        cyc();
        chk1 ("abort_busy",     busy,         1'b0);
        chk1 ("abort_done",     done,         1'b0);
        chk16("abort_parallel", parallel_out, 16'h001F);
        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        cyc();
        chk1 ("abort_done_later", done,        1'b0);
        chk16("abort_aligned",    aligned_out, 16'hFFFF);

        // Asynchronous reset between edges mid-frame
        drive(1, 16'h5555, 8, 1, 0, 0, 0);
        cyc();
        drive(0, 16'h0000, 0, 0, 1, 0, 0);
        cyc();
        chk16("pre_rst_parallel", parallel_out, 16'hAAAA);
        chk1 ("pre_rst_shift_out", shift_out,   1'b1);
        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk1 ("async_rst_shift_out",   shift_out,    1'b0);
        chk16("async_rst_parallel",    parallel_out, 16'h0000);
        chk16("async_rst_aligned",     aligned_out,  16'h0000);
        chk1 ("async_rst_busy",        busy,         1'b0);
        chk1 ("async_rst_done",        done,         1'b0);
        chk1 ("async_rst_start_ready", start_ready,  1'b1);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk1("post_rst_done", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
